// File: rtl/note_change_scheduler.sv
// note_change_scheduler: queues valid midi keys and releases one freq_id per vsync frame, pacing on wave_ready
// Ports: clock, reset (async, active-high); midi_ready/key_index key intake; vsync frame timing;
//  wave_ready from wave_logic; freq_id/new_freq target update; pending queue fill;
//  reject/overflow 1-cycle pulses; timeout sticky ready-wait expiry.
// Build option: NOTE_SCHED_LATEST_WINS_EN makes a push into a full queue overwrite the tail entry.
module note_change_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int KEY_BASE      = 48,
  parameter int NUM_FREQS     = 32,
  parameter int MIN_FRAMES    = 1,
  parameter int RESET_FREQ    = 0,
  parameter int READY_TIMEOUT = 1048576
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_ready,
  input  logic [6:0] key_index,
  input  logic       vsync,
  input  logic       wave_ready,
  output logic [4:0] freq_id,
  output logic       new_freq,
  output logic [4:0] pending,
  output logic       reject,
  output logic       overflow,
  output logic       timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT_FRAME = 2'd1, ISSUE = 2'd2, WAIT_READY = 2'd3;
  localparam logic [6:0] KB = 7'(KEY_BASE);
  localparam logic [6:0] NF = 7'(NUM_FREQS);
  localparam logic [3:0] MF = 4'(MIN_FRAMES);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
  localparam logic [TW-1:0] RT_LAST = TW'(READY_TIMEOUT - 1);
  logic [4:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0] key_off;
  logic key_ok, full, pop, push, clobber, vsync_q, vs_rise, release_now, ready_ok, expired;
  logic [3:0] frame_cnt, frame_inc;
  logic [1:0] state, state_nx, hold;
  logic [TW-1:0] wait_cnt;
  assign key_off = key_index - KB;
  assign key_ok = midi_ready && key_index >= KB && key_off < NF;
  assign full = pending == DEPTH;
  assign pop = state == ISSUE;
  assign push = key_ok && (!full || pop);
`ifdef NOTE_SCHED_LATEST_WINS_EN
  assign clobber = key_ok && full && !pop;
`else
  assign clobber = 1'b0;
`endif
  assign vs_rise = vsync && !vsync_q;
  // the edge that satisfies the gap is itself counted, so the check uses the incremented value
  assign frame_inc = vs_rise && frame_cnt < MF ? frame_cnt + 4'd1 : frame_cnt;
  assign release_now = state == WAIT_FRAME && vs_rise && frame_inc >= MF;
  // hold masks wave_ready during the new_freq cycle and the two after it
  assign ready_ok = state == WAIT_READY && hold == 2'd0 && wave_ready;
  assign expired = state == WAIT_READY && !ready_ok && wait_cnt == RT_LAST;
  always_comb begin
    state_nx = state == IDLE       ? (pending != 5'd0 ? WAIT_FRAME : IDLE) :
               state == WAIT_FRAME ? (release_now ? ISSUE : WAIT_FRAME) :
               state == ISSUE      ? WAIT_READY :
               (ready_ok || expired ? IDLE : WAIT_READY);
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= key_off[4:0];
    else if (clobber) mem[wr_ptr - AW'(1)] <= key_off[4:0];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      freq_id <= 5'(RESET_FREQ);
      new_freq <= 1'b0;
      reject <= 1'b0;
      overflow <= 1'b0;
      timeout <= 1'b0;
      pending <= 5'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      vsync_q <= 1'b0;
      frame_cnt <= MF;
      hold <= 2'd0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      vsync_q <= vsync;
      new_freq <= pop;
      reject <= midi_ready && !key_ok;
      overflow <= key_ok && full && !pop;
      timeout <= timeout || expired;
      frame_cnt <= pop ? 4'd0 : frame_inc;
      pending <= pending + 5'(push) - 5'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (pop) freq_id <= mem[rd_ptr];
      hold <= pop ? 2'd3 : hold - 2'(hold != 2'd0);
      wait_cnt <= pop ? '0 : wait_cnt + TW'(state == WAIT_READY);
    end
  end
endmodule

// File: tb/tb_note_change_scheduler.sv
// tb_note_change_scheduler: directed checks of intake, frame pacing, overflow order, ready timeout and reset
module tb_note_change_scheduler;
  logic clock = 1'b0, reset = 1'b1, midi_ready = 1'b0, vsync = 1'b0, wave_ready = 1'b0;
  logic [6:0] key_index = 7'd0;
  logic [4:0] f0, p0, f1, p1;
  logic nf0, rj0, ov0, to0, nf1, rj1, ov1, to1;
  int total = 0, bad = 0, vph = 0, edges = 0;
  bit vs_auto = 1'b0;
`ifdef NOTE_SCHED_LATEST_WINS_EN
  int exp5[4] = '{1, 2, 3, 5};
`else
  int exp5[4] = '{1, 2, 3, 4};
`endif
  always #5 clock = ~clock;
  note_change_scheduler #(.MIN_FRAMES(1), .READY_TIMEOUT(64)) u0 (
    .clock(clock), .reset(reset), .midi_ready(midi_ready), .key_index(key_index),
    .vsync(vsync), .wave_ready(wave_ready), .freq_id(f0), .new_freq(nf0),
    .pending(p0), .reject(rj0), .overflow(ov0), .timeout(to0));
  note_change_scheduler #(.MIN_FRAMES(2), .READY_TIMEOUT(64)) u1 (
    .clock(clock), .reset(reset), .midi_ready(midi_ready), .key_index(key_index),
    .vsync(vsync), .wave_ready(wave_ready), .freq_id(f1), .new_freq(nf1),
    .pending(p1), .reject(rj1), .overflow(ov1), .timeout(to1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
    vph++;
    if (vs_auto) begin
      vsync = (vph % 16) == 0;
      if (vsync) edges++;
    end
  endtask
  task automatic push_key(input int k);
    midi_ready = 1'b1;
    key_index = 7'(k);
    tick;
    midi_ready = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    vs_auto = 1'b0;
    vsync = 1'b0;
    midi_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask
  task automatic wait_nf(input bit sel, output logic [4:0] f);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!(sel ? nf1 : nf0) && n < 300);
    chk("nf_wait", 32'(n < 300), 32'd1);
    f = sel ? f1 : f0;
  endtask
  initial begin
    logic [4:0] f;
    int e1;
    bit seen;
    do_reset;
    for (int i = 0; i < 100; i++) begin
      tick;
      chk("idle", 32'({f0, nf0, p0, rj0, ov0, to0}), 32'd0);
    end
    wave_ready = 1'b1;
    push_key(60);
    chk("t2_pend", 32'(p0), 32'd1);
    tick;
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    chk("t2_nf_early", 32'(nf0), 32'd0);
    tick;
    chk("t2_freq", 32'(f0), 32'd12);
    chk("t2_nf", 32'(nf0), 32'd1);
    chk("t2_pend0", 32'(p0), 32'd0);
    tick;
    chk("t2_nf_width", 32'(nf0), 32'd0);
    chk("t2_hold", 32'(f0), 32'd12);
    repeat (10) tick;
    push_key(47);
    chk("t3_rej47", 32'(rj0), 32'd1);
    tick;
    chk("t3_rej_pulse", 32'(rj0), 32'd0);
    push_key(80);
    chk("t3_rej80", 32'(rj0), 32'd1);
    chk("t3_pend", 32'(p0), 32'd0);
    vs_auto = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick;
      seen |= nf0;
    end
    chk("t3_no_nf", 32'(seen), 32'd0);
    do_reset;
    wave_ready = 1'b1;
    push_key(50);
    push_key(51);
    push_key(52);
    vs_auto = 1'b1;
    wait_nf(1'b1, f);
    chk("t4_f0", 32'(f), 32'd2);
    e1 = edges;
    wait_nf(1'b1, f);
    chk("t4_f1", 32'(f), 32'd3);
    chk("t4_gap1", 32'(edges - e1), 32'd2);
    e1 = edges;
    wait_nf(1'b1, f);
    chk("t4_f2", 32'(f), 32'd4);
    chk("t4_gap2", 32'(edges - e1), 32'd2);
    do_reset;
    wave_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_key(49 + i);
      chk("t5_ovf", 32'(ov0), 32'(i == 4));
    end
    chk("t5_pend_full", 32'(p0), 32'd4);
    tick;
    chk("t5_ovf_pulse", 32'(ov0), 32'd0);
    vs_auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_nf(1'b0, f);
      chk("t5_order", 32'(f), 32'(exp5[i]));
    end
    chk("t5_pend_empty", 32'(p0), 32'd0);
    do_reset;
    wave_ready = 1'b0;
    push_key(55);
    push_key(56);
    vs_auto = 1'b1;
    wait_nf(1'b0, f);
    chk("t6_f7", 32'(f), 32'd7);
    chk("t6_to_start", 32'(to0), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      tick;
      if (i == 63) chk("t6_to_early", 32'(to0), 32'd0);
    end
    chk("t6_to", 32'(to0), 32'd1);
    wait_nf(1'b0, f);
    chk("t6_f8", 32'(f), 32'd8);
    chk("t6_to_sticky", 32'(to0), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_rst", 32'({f0, nf0, p0, rj0, ov0, to0}), 32'd0);
    tick;
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
